// File: rtl/fft8_framer.sv
`default_nettype none
// ============================================================================
// Module   : fft8_framer
// Purpose  : Assembles a stream of unsigned samples into 8-sample frames for
//            the 8-point FFT core. Completed frames are presented in parallel
//            on o_x0..o_x7 (o_x0 oldest) and held until the next transfer.
//            A result-valid strobe follows each frame strobe by FFT_LAT
//            cycles so capture logic knows when the FFT outputs are new.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_s_data/valid/sof - sample stream with start-of-frame marker
//            o_s_ready         - sample can be accepted this cycle
//            i_hold            - defers transfer of a completed frame
//            o_x0..o_x7        - parallel frame to the FFT core
//            o_frame_strobe    - first cycle a new frame is on o_x*
//            o_result_valid    - first cycle FFT outputs reflect new frame
//            o_drop_cnt        - saturating count of discarded partial frames
// Revision : 1.0 - initial release
// ============================================================================
module fft8_framer #(
  parameter int DATA_W  = 8,
  parameter int FFT_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  input  logic              i_s_sof,
  output logic              o_s_ready,
  input  logic              i_hold,
  output logic [DATA_W-1:0] o_x0,
  output logic [DATA_W-1:0] o_x1,
  output logic [DATA_W-1:0] o_x2,
  output logic [DATA_W-1:0] o_x3,
  output logic [DATA_W-1:0] o_x4,
  output logic [DATA_W-1:0] o_x5,
  output logic [DATA_W-1:0] o_x6,
  output logic [DATA_W-1:0] o_x7,
  output logic              o_frame_strobe,
  output logic              o_result_valid,
  output logic [7:0]        o_drop_cnt
);

  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_buf [0:7];
  logic [DATA_W-1:0] r_x   [0:7];
  logic              r_strobe;
  logic [FFT_LAT-1:0] r_dly;
  logic [7:0]        r_drop;
  logic              w_accept;

  // Ready is a pure decode of the state register: FILL never stalls.
  assign o_s_ready = (r_state == ST_FILL);
  assign w_accept  = i_s_valid && o_s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_idx    <= 3'd0;
      r_strobe <= 1'b0;
      r_dly    <= '0;
      r_drop   <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        r_buf[i] <= '0;
        r_x[i]   <= '0;
      end
    end else begin
      r_strobe <= 1'b0;

      // Strobe delay line modelling the FFT core pipeline.
      r_dly[0] <= r_strobe;
      for (int i = 1; i < FFT_LAT; i++) begin
        r_dly[i] <= r_dly[i-1];
      end

      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            if (i_s_sof) begin
              // Resync: this sample starts a new frame; any partial
              // frame (including 7 buffered samples) is discarded.
              r_buf[0] <= i_s_data;
              r_idx    <= 3'd1;
              if (r_idx != 3'd0 && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
              end
            end else if (r_idx == 3'd7) begin
              r_idx <= 3'd0;
              if (!i_hold) begin
                // Bypass slot 7 so the frame lands on the same edge.
                for (int i = 0; i < 7; i++) begin
                  r_x[i] <= r_buf[i];
                end
                r_x[7]   <= i_s_data;
                r_strobe <= 1'b1;
              end else begin
                r_buf[7] <= i_s_data;
                r_state  <= ST_PENDING;
              end
            end else begin
              r_buf[r_idx] <= i_s_data;
              r_idx        <= r_idx + 3'd1;
            end
          end
        end
        ST_PENDING: begin
          if (!i_hold) begin
            for (int i = 0; i < 8; i++) begin
              r_x[i] <= r_buf[i];
            end
            r_strobe <= 1'b1;
            r_state  <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign o_x0           = r_x[0];
  assign o_x1           = r_x[1];
  assign o_x2           = r_x[2];
  assign o_x3           = r_x[3];
  assign o_x4           = r_x[4];
  assign o_x5           = r_x[5];
  assign o_x6           = r_x[6];
  assign o_x7           = r_x[7];
  assign o_frame_strobe = r_strobe;
  assign o_result_valid = r_dly[FFT_LAT-1];
  assign o_drop_cnt     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fft8_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft8_framer
// Purpose  : Self-checking bench for fft8_framer: table-driven streaming
//            vectors plus hand-written hold, resync, saturation and
//            asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft8_framer;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_sof;
  logic       s_ready;
  logic       hold;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic       frame_strobe;
  logic       result_valid;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fft8_framer #(.DATA_W(8), .FFT_LAT(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_s_data       (s_data),
    .i_s_valid      (s_valid),
    .i_s_sof        (s_sof),
    .o_s_ready      (s_ready),
    .i_hold         (hold),
    .o_x0           (x0),
    .o_x1           (x1),
    .o_x2           (x2),
    .o_x3           (x3),
    .o_x4           (x4),
    .o_x5           (x5),
    .o_x6           (x6),
    .o_x7           (x7),
    .o_frame_strobe (frame_strobe),
    .o_result_valid (result_valid),
    .o_drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        sof;
    logic [7:0]  d;
    logic        h;
    logic        rdy;
    logic        stb;
    logic        rv;
    logic [7:0]  drop;
    logic [63:0] x;
  } vec_t;

  vec_t tbl [20];

  localparam logic [63:0] F_1_8   = 64'h0807060504030201;
  localparam logic [63:0] F_9_16  = 64'h100F0E0D0C0B0A09;

  function automatic logic [63:0] xbus();
    return {x7, x6, x5, x4, x3, x2, x1, x0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, return at the following falling edge.
  task automatic step(input logic v, input logic sof, input logic [7:0] d, input logic h);
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    hold    = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = 8'd0;
    hold    = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    // ---------------- table: alignment + back-to-back frames -----------
    for (int i = 0; i < 20; i++) begin
      tbl[i].v    = (i < 16);
      tbl[i].sof  = 1'b0;
      tbl[i].d    = (i < 16) ? 8'(i + 1) : 8'h00;
      tbl[i].h    = 1'b0;
      tbl[i].rdy  = 1'b1;
      tbl[i].stb  = (i == 7) || (i == 15);
      tbl[i].rv   = (i == 10) || (i == 18);
      tbl[i].drop = 8'd0;
      tbl[i].x    = (i < 7) ? 64'd0 : (i < 15) ? F_1_8 : F_9_16;
    end

    reset_dut();
    chk("reset_state", {s_ready, frame_strobe, result_valid, drop_cnt, xbus()},
        {1'b1, 1'b0, 1'b0, 8'd0, 64'd0});

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].h);
      chk($sformatf("stream_row%0d", i),
          {s_ready, frame_strobe, result_valid, drop_cnt, xbus()},
          {tbl[i].rdy, tbl[i].stb, tbl[i].rv, tbl[i].drop, tbl[i].x});
    end

    // ---------------- hold deferral ------------------------------------
    reset_dut();
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(k), 1'b1);
    chk("hold_no_block_ready", {63'd0, s_ready}, 64'd1);
    step(1'b1, 1'b0, 8'd8, 1'b1);
    chk("hold_pending", {s_ready, frame_strobe, xbus()}, {1'b0, 1'b0, 64'd0});
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 8'h99, 1'b1);
      chk($sformatf("hold_wait%0d", k), {s_ready, frame_strobe, xbus()}, {1'b0, 1'b0, 64'd0});
    end
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("hold_transfer", {s_ready, frame_strobe, xbus()}, {1'b1, 1'b1, F_1_8});
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("hold_strobe_once", {63'd0, frame_strobe}, 64'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'h11 + k), 1'b0);
    chk("hold_next_frame", {frame_strobe, xbus()}, {1'b1, 64'h1817161514131211});

    // ---------------- partial-frame resync -----------------------------
    reset_dut();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 8'(k), 1'b0);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("resync_drop1", {56'd0, drop_cnt}, 64'd1);
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(8'hB0 + k), 1'b0);
    chk("resync_frame", {frame_strobe, xbus()}, {1'b1, 64'hB7B6B5B4B3B2B1AA});
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(k), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("sof_on_8th", {frame_strobe, drop_cnt, xbus()}, {1'b0, 8'd2, 64'hB7B6B5B4B3B2B1AA});
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(8'h60 + k), 1'b0);
    chk("sof8_next_frame", {frame_strobe, xbus()}, {1'b1, 64'h6766656463626155});
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("sof_idx0_no_drop", {56'd0, drop_cnt}, 64'd2);

    // ---------------- drop counter saturation --------------------------
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 8'h01, 1'b0);
      step(1'b1, 1'b1, 8'h02, 1'b0);
      if (i == 253) chk("drop_254", {56'd0, drop_cnt}, 64'd254);
    end
    chk("drop_saturate", {56'd0, drop_cnt}, 64'd255);

    // ---------------- asynchronous reset mid-frame ---------------------
    reset_dut();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 8'(k), 1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(8'h10 + k), 1'b0);
    chk("pre_reset_frame", {frame_strobe, drop_cnt, xbus()}, {1'b1, 8'd1, 64'h1716151413121110});
    step(1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst_mid", {s_ready, frame_strobe, result_valid, drop_cnt, xbus()},
           {1'b1, 1'b0, 1'b0, 8'd0, 64'd0});
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0);
      chk($sformatf("rst_rv_cleared%0d", k), {62'd0, result_valid, frame_strobe}, 64'd0);
    end
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 8'(8'h20 + k), 1'b0);
    chk("post_rst_frame", {frame_strobe, xbus()}, {1'b1, 64'h2827262524232221});

    // ---------------- asynchronous reset in PENDING --------------------
    reset_dut();
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b0, 8'(k), 1'b0);
    step(1'b1, 1'b0, 8'd8, 1'b1);
    chk("pend_before_rst", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_rst_pend", {s_ready, frame_strobe, result_valid, drop_cnt, xbus()},
           {1'b1, 1'b0, 1'b0, 8'd0, 64'd0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'd0, 1'b0);
    chk("pend_lost", {frame_strobe, xbus()}, {1'b0, 64'd0});
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 8'(8'h30 + k), 1'b0);
    chk("post_pend_frame", {frame_strobe, xbus()}, {1'b1, 64'h3837363534333231});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
